// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequences the shared multi-cycle mul/div unit, stalls the pipeline, issues one writeback.
// Optional build macro MULTDIV_TIMEOUT_EN forces an exception when the unit never answers.
module multdiv_ctrl #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 40,
  parameter int RSTATUS_MUL = 4,
  parameter int RSTATUS_DIV = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [4:0]        op,
  input  logic [4:0]        alu_op,
  input  logic              dx_valid,
  input  logic [4:0]        dx_rd,
  input  logic              flush,
  output logic              md_ctrl_mult,
  output logic              md_ctrl_div,
  input  logic [DATA_W-1:0] md_result,
  input  logic              md_exception,
  input  logic              md_ready,
  output logic              stall,
  output logic              busy,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [31:0]       rstatus
);

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [4:0]        EXC_RD   = 5'd30;
  localparam logic [31:0]       CODE_MUL = 32'(RSTATUS_MUL);
  localparam logic [31:0]       CODE_DIV = 32'(RSTATUS_DIV);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_e;

  state_e              state_q, state_d;
  logic [4:0]          latchedRd_q, latchedRd_d;
  logic                kindDiv_q, kindDiv_d;
  logic [CNT_W-1:0]    waitCnt_q, waitCnt_d;
  logic                exc_q, exc_d;
  logic [4:0]          wbRd_q, wbRd_d;
  logic [DATA_W-1:0]   wbData_q, wbData_d;
  logic [31:0]         rstatus_q, rstatus_d;

  logic isMul, isDiv, start;
  logic capture, capExc;
  logic multPulse, divPulse, stallC, wbValidC;
  logic [31:0] kindCode;

  assign isMul    = (op == 5'd0) && (alu_op == 5'b00110);
  assign isDiv    = (op == 5'd0) && (alu_op == 5'b00111);
  assign start    = dx_valid && (isMul || isDiv) && !flush;
  assign kindCode = kindDiv_q ? CODE_DIV : CODE_MUL;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      latchedRd_q <= '0;
      kindDiv_q   <= 1'b0;
      waitCnt_q   <= '0;
      exc_q       <= 1'b0;
      wbRd_q      <= '0;
      wbData_q    <= '0;
      rstatus_q   <= '0;
    end else begin
      state_q     <= state_d;
      latchedRd_q <= latchedRd_d;
      kindDiv_q   <= kindDiv_d;
      waitCnt_q   <= waitCnt_d;
      exc_q       <= exc_d;
      wbRd_q      <= wbRd_d;
      wbData_q    <= wbData_d;
      rstatus_q   <= rstatus_d;
    end
  end

  // wb_rd/wb_data are resolved when the result is captured so they hold steady after DONE.
  always_comb begin
    state_d     = state_q;
    latchedRd_d = latchedRd_q;
    kindDiv_d   = kindDiv_q;
    waitCnt_d   = waitCnt_q;
    exc_d       = exc_q;
    wbRd_d      = wbRd_q;
    wbData_d    = wbData_q;
    rstatus_d   = rstatus_q;
    capture     = 1'b0;
    capExc      = 1'b0;
    multPulse   = 1'b0;
    divPulse    = 1'b0;
    stallC      = 1'b0;
    wbValidC    = 1'b0;

    case (state_q)
      IDLE: begin
        stallC = start;
        if (start) begin
          state_d     = START;
          latchedRd_d = dx_rd;
          kindDiv_d   = isDiv;
        end
      end
      START: begin
        stallC    = 1'b1;
        waitCnt_d = '0;
        if (flush) begin
          state_d = IDLE;
        end else begin
          multPulse = !kindDiv_q;
          divPulse  = kindDiv_q;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        stallC = 1'b1;
        if (waitCnt_q != CNT_MAX) waitCnt_d = waitCnt_q + 1'b1;
        if (flush) begin
          state_d = IDLE;
        end else if (md_ready) begin
          capture = 1'b1;
          capExc  = md_exception;
        end
`ifdef MULTDIV_TIMEOUT_EN
        else if (waitCnt_q == CNT_W'(TIMEOUT - 1)) begin
          capture = 1'b1;
          capExc  = 1'b1;
        end
`endif
      end
      DONE: begin
        wbValidC  = 1'b1;
        rstatus_d = exc_q ? kindCode : 32'd0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      state_d  = DONE;
      exc_d    = capExc;
      wbRd_d   = capExc ? EXC_RD : latchedRd_q;
      wbData_d = capExc ? DATA_W'(kindCode) : md_result;
    end
  end

  assign md_ctrl_mult = multPulse;
  assign md_ctrl_div  = divPulse;
  assign stall        = stallC;
  assign busy         = (state_q != IDLE);
  assign wb_valid     = wbValidC;
  assign wb_rd        = wbRd_q;
  assign wb_data      = wbData_q;
  assign rstatus      = rstatus_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb_multdiv_ctrl: randomized scoreboard bench for multdiv_ctrl.
// Expected writebacks are queued by the driver and popped by an independent monitor.
module tb_multdiv_ctrl;

  localparam int TIMEOUT = 40;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  op = '0;
  logic [4:0]  alu_op = '0;
  logic        dx_valid = 1'b0;
  logic [4:0]  dx_rd = '0;
  logic        flush = 1'b0;
  logic        md_ctrl_mult, md_ctrl_div;
  logic [31:0] md_result = '0;
  logic        md_exception = 1'b0;
  logic        md_ready = 1'b0;
  logic        stall, busy, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] rstatus;

  multdiv_ctrl dut (
    .clock(clock), .reset(reset), .op(op), .alu_op(alu_op), .dx_valid(dx_valid),
    .dx_rd(dx_rd), .flush(flush), .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready),
    .stall(stall), .busy(busy), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .rstatus(rstatus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] status;
    int          cycle;
  } expect_t;

  expect_t     expQ[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          expMulPulses = 0, expDivPulses = 0;
  int          actMulPulses = 0, actDivPulses = 0;
  logic [31:0] lastStatus = '0;
  bit          statusPending = 1'b0;
  logic [31:0] pendingStatus = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples shortly after the falling edge so driver updates have settled.
  always @(negedge clock) begin
    expect_t e;
    #2;
    if (statusPending) begin
      statusPending = 1'b0;
      checkOutput("rstatus_after_wb", rstatus, pendingStatus);
    end
    if (md_ctrl_mult === 1'b1) actMulPulses++;
    if (md_ctrl_div === 1'b1) actDivPulses++;
    if (wb_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_wb_valid", 64'(wb_valid), 64'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("wb_rd", 64'(wb_rd), 64'(e.rd));
        checkOutput("wb_data", 64'(wb_data), 64'(e.data));
        checkOutput("wb_cycle", 64'(cyc), 64'(e.cycle));
        statusPending = 1'b1;
        pendingStatus = e.status;
      end
    end
  end

  // One mul/div instruction. abortKind: 0 none, 1 flush at abortAt (0=START, k=WAIT k), 2 reset at WAIT abortAt.
  task automatic applyStimulus(input bit isDivOp, input logic [4:0] rd, input int n, input bit exc,
                               input logic [31:0] res, input int abortKind, input int abortAt,
                               input bit doneFlush);
    int stallCnt = 0;
    int busyCnt = 0;
    bit resetPending = 1'b0;
    bit doCheck;
    logic [31:0] code;
    expect_t e;
    code = isDivOp ? 32'd5 : 32'd4;

    @(negedge clock);
    op = 5'd0; alu_op = isDivOp ? 5'd7 : 5'd6; dx_rd = rd; dx_valid = 1'b1;
    flush = 1'b0; md_ready = 1'b0; reset = 1'b0;
    #1;
    stallCnt += int'(stall); busyCnt += int'(busy);
    if (abortKind == 0) begin
      e.rd = exc ? 5'd30 : rd;
      e.data = exc ? code : res;
      e.status = exc ? code : 32'd0;
      e.cycle = cyc + n + 2;
      expQ.push_back(e);
      lastStatus = e.status;
    end
    if (!(abortKind == 1 && abortAt == 0)) begin
      if (isDivOp) expDivPulses++; else expMulPulses++;
    end

    @(negedge clock);
    dx_valid = 1'b0;
    flush = (abortKind == 1 && abortAt == 0);
    #1;
    stallCnt += int'(stall); busyCnt += int'(busy);

    for (int k = 1; k <= n; k++) begin
      @(negedge clock);
      doCheck = resetPending; resetPending = 1'b0; reset = 1'b0;
      flush = (abortKind == 1 && abortAt == k);
      if (abortKind == 2 && abortAt == k) begin
        reset = 1'b1; resetPending = 1'b1;
      end
      md_ready = (k == n);
      md_result = (k == n) ? res : $urandom;
      md_exception = (k == n) ? exc : 1'($urandom_range(0, 1));
      #1;
      stallCnt += int'(stall); busyCnt += int'(busy);
      if (doCheck) begin
        checkOutput("reset_ctrl", 64'({md_ctrl_mult, md_ctrl_div, stall, busy, wb_valid, wb_rd}), 64'd0);
        checkOutput("reset_wb_data", 64'(wb_data), 64'd0);
        checkOutput("reset_rstatus", 64'(rstatus), 64'd0);
      end
    end

    @(negedge clock);
    doCheck = resetPending; reset = 1'b0;
    flush = (abortKind == 0) && doneFlush;
    md_ready = 1'b0;
    #1;
    stallCnt += int'(stall); busyCnt += int'(busy);
    if (doCheck) begin
      checkOutput("reset_ctrl", 64'({md_ctrl_mult, md_ctrl_div, stall, busy, wb_valid, wb_rd}), 64'd0);
      checkOutput("reset_wb_data", 64'(wb_data), 64'd0);
      checkOutput("reset_rstatus", 64'(rstatus), 64'd0);
    end

    if (abortKind == 2) lastStatus = 32'd0;
    checkOutput("stall_cycles", 64'(stallCnt), 64'((abortKind != 0) ? abortAt + 2 : n + 2));
    checkOutput("busy_cycles", 64'(busyCnt), 64'((abortKind != 0) ? abortAt + 1 : n + 2));
    if (abortKind != 0) checkOutput("rstatus_after_abort", 64'(rstatus), 64'(lastStatus));
  endtask

  // Instructions that must not start the unit: wrong decode, or a mul/div being flushed.
  task automatic applyNoise();
    int a;
    @(negedge clock);
    dx_valid = 1'b1; flush = 1'b0; dx_rd = 5'($urandom);
    case ($urandom_range(0, 2))
      0: begin op = 5'($urandom_range(1, 31)); alu_op = $urandom_range(0, 1) ? 5'd6 : 5'd7; end
      1: begin
        op = 5'd0;
        a = $urandom_range(0, 29);
        if (a >= 6) a += 2;
        alu_op = 5'(a);
      end
      default: begin op = 5'd0; alu_op = $urandom_range(0, 1) ? 5'd6 : 5'd7; flush = 1'b1; end
    endcase
    #1;
    checkOutput("noise_stall", 64'(stall), 64'd0);
    @(negedge clock);
    dx_valid = 1'b0; flush = 1'b0;
    #1;
    checkOutput("noise_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, kind, abortAt;
    bit isDivOp;
    expect_t e;

    repeat (3) @(negedge clock);
    #1;
    checkOutput("init_ctrl", 64'({md_ctrl_mult, md_ctrl_div, stall, busy, wb_valid, wb_rd}), 64'd0);
    checkOutput("init_wb_data", 64'(wb_data), 64'd0);
    checkOutput("init_rstatus", 64'(rstatus), 64'd0);
    reset = 1'b0;

    applyStimulus(1'b0, 5'd7, 16, 1'b0, 32'd42, 0, 0, 1'b0);
    applyStimulus(1'b1, 5'd9, 10, 1'b1, $urandom, 0, 0, 1'b0);
    applyStimulus(1'b0, 5'd12, 12, 1'b0, 32'd99, 1, 3, 1'b0);
    applyStimulus(1'b0, 5'd4, 5, 1'b0, 32'd123, 0, 0, 1'b0);
    applyStimulus(1'b1, 5'd6, 7, 1'b0, 32'd456, 0, 0, 1'b0);
    applyStimulus(1'b0, 5'd8, 10, 1'b0, 32'd77, 2, 4, 1'b0);
    applyStimulus(1'b1, 5'd3, 6, 1'b0, 32'd55, 1, 6, 1'b0);
    applyStimulus(1'b1, 5'd2, 4, 1'b0, 32'd11, 1, 0, 1'b0);
    applyStimulus(1'b0, 5'd5, 3, 1'b1, 32'd0, 0, 0, 1'b1);
    applyStimulus(1'b0, 5'd1, 1, 1'b0, 32'hDEADBEEF, 0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      applyNoise();
      n = $urandom_range(1, 20);
      isDivOp = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        abortAt = $urandom_range(0, n);
        applyStimulus(isDivOp, 5'($urandom), n, 1'($urandom_range(0, 1)), $urandom, 1, abortAt, 1'b0);
      end else if (kind == 1) begin
        abortAt = $urandom_range(1, n);
        applyStimulus(isDivOp, 5'($urandom), n, 1'($urandom_range(0, 1)), $urandom, 2, abortAt, 1'b0);
      end else begin
        applyStimulus(isDivOp, 5'($urandom), n, 1'($urandom_range(0, 1)), $urandom, 0, 0,
                      1'($urandom_range(0, 1)));
      end
    end

`ifdef MULTDIV_TIMEOUT_EN
    // The unit never answers: a forced mul exception is expected after TIMEOUT wait cycles.
    @(negedge clock);
    op = 5'd0; alu_op = 5'd6; dx_rd = 5'd11; dx_valid = 1'b1; flush = 1'b0; md_ready = 1'b0;
    #1;
    e.rd = 5'd30; e.data = 32'd4; e.status = 32'd4; e.cycle = cyc + TIMEOUT + 2;
    expQ.push_back(e);
    lastStatus = 32'd4;
    expMulPulses++;
    @(negedge clock);
    dx_valid = 1'b0;
    repeat (TIMEOUT + 3) @(negedge clock);
    #3;
    checkOutput("timeout_wb_seen", 64'(expQ.size()), 64'd0);
    checkOutput("timeout_rstatus", 64'(rstatus), 64'd4);
`else
    // Without a timeout the controller waits as long as it takes; a flush is the only way out.
    applyStimulus(1'b0, 5'd3, 60, 1'b0, 32'd1, 1, 60, 1'b0);
`endif

    repeat (3) @(negedge clock);
    #3;
    checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
    checkOutput("mul_pulses", 64'(actMulPulses), 64'(expMulPulses));
    checkOutput("div_pulses", 64'(actDivPulses), 64'(expDivPulses));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
